// File: rtl/cpu_output_fifo.sv
// Show-ahead FIFO buffering CPU result words for a slower valid/ready sink; sticky overflow on dropped pushes.
// Optional drop counter output enabled by defining CPU_OUTPUT_FIFO_DROP_COUNT_EN.
module cpu_output_fifo #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 8,
  parameter int CNT_WIDTH  = $clog2(DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_strobe,
  input  logic                  flush,
  input  logic                  clear_flags,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [CNT_WIDTH-1:0]  level,
  output logic                  full,
  output logic                  overflow
`ifdef CPU_OUTPUT_FIFO_DROP_COUNT_EN
  ,
  output logic [7:0]            drop_count
`endif
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0]      rd_ptr;
  logic [PTR_W-1:0]      wr_ptr;
  logic                  pop;
  logic                  push;
  logic                  drop;
  logic [CNT_WIDTH-1:0]  level_next;

  assign out_valid  = (level != '0);
  assign full       = (level == CNT_WIDTH'(DEPTH));
  assign pop        = out_valid & out_ready;
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign push       = in_strobe & (~full | pop);
  assign drop       = in_strobe & full & ~pop;
  assign out_data   = out_valid ? mem[rd_ptr] : '0;
  assign level_next = level + CNT_WIDTH'(push) - CNT_WIDTH'(pop);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      level  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      level <= level_next;
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (reset && push && !flush) mem[wr_ptr] <= in_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)           overflow <= 1'b0;
    else if (drop)        overflow <= 1'b1;
    else if (clear_flags) overflow <= 1'b0;
  end

`ifdef CPU_OUTPUT_FIFO_DROP_COUNT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                          drop_count <= 8'd0;
    else if (clear_flags)                drop_count <= drop ? 8'd1 : 8'd0;
    else if (drop && drop_count != 8'hFF) drop_count <= drop_count + 8'd1;
  end
`endif

endmodule

// File: tb/tb_cpu_output_fifo.sv
// Directed bench for cpu_output_fifo: vector table plus hand-written reset, wrap and overflow sequences.
module tb_cpu_output_fifo;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] in_data;
  logic        in_strobe;
  logic        flush;
  logic        clear_flags;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  level;
  logic        full;
  logic        overflow;
`ifdef CPU_OUTPUT_FIFO_DROP_COUNT_EN
  logic [7:0]  drop_count;
`endif

  int pass_cnt = 0;
  int total    = 0;

  cpu_output_fifo dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_strobe(in_strobe),
    .flush(flush), .clear_flags(clear_flags), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .level(level),
    .full(full), .overflow(overflow)
`ifdef CPU_OUTPUT_FIFO_DROP_COUNT_EN
    , .drop_count(drop_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        strobe;
    logic [15:0] din;
    logic        rdy;
    logic        fl;
    logic        clr;
    logic [3:0]  e_lvl;
    logic        e_vld;
    logic [15:0] e_dat;
    logic        e_full;
    logic        e_ovf;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic add(input logic s, input logic [15:0] d, input logic r, input logic f,
                     input logic c, input logic [3:0] l, input logic v, input logic [15:0] od,
                     input logic fu, input logic ov);
    vec_t x;
    x.strobe = s; x.din = d; x.rdy = r; x.fl = f; x.clr = c;
    x.e_lvl = l; x.e_vld = v; x.e_dat = od; x.e_full = fu; x.e_ovf = ov;
    vecs.push_back(x);
  endtask

  task automatic drive(input logic s, input logic [15:0] d, input logic r, input logic f, input logic c);
    in_strobe = s; in_data = d; out_ready = r; flush = f; clear_flags = c;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_state(input string tag, input logic [3:0] l, input logic [15:0] d, input logic ov);
    check({tag, " level"}, 32'(level), 32'(l));
    check({tag, " valid"}, 32'(out_valid), 32'(l != 0));
    check({tag, " data"}, 32'(out_data), 32'(d));
    check({tag, " full"}, 32'(full), 32'(l == 4'd8));
    check({tag, " ovf"}, 32'(overflow), 32'(ov));
  endtask

  initial begin
    reset = 1'b0;
    drive(0, 16'h0, 0, 0, 0);
    #3;
    check_state("reset", 4'd0, 16'h0, 1'b0);
    step();
    reset = 1'b1;

    // strobe din rdy flush clr | level valid data full ovf
    add(1, 16'h1234, 0, 0, 0, 1, 1, 16'h1234, 0, 0);
    add(1, 16'hABCD, 0, 0, 0, 2, 1, 16'h1234, 0, 0);
    add(0, 16'h0000, 1, 0, 0, 1, 1, 16'hABCD, 0, 0);
    add(0, 16'h0000, 1, 0, 0, 0, 0, 16'h0000, 0, 0);
    add(1, 16'h0055, 1, 0, 0, 1, 1, 16'h0055, 0, 0);  // no bypass into empty FIFO
    add(0, 16'h0000, 1, 0, 0, 0, 0, 16'h0000, 0, 0);
    for (int i = 1; i <= 8; i++)
      add(1, 16'(i), 0, 0, 0, 4'(i), 1, 16'h0001, i == 8, 0);
    add(1, 16'h0009, 0, 0, 0, 8, 1, 16'h0001, 1, 1);  // dropped
    add(1, 16'h000A, 1, 0, 1, 8, 1, 16'h0002, 1, 0);  // push+pop at full, clear
    for (int i = 3; i <= 8; i++)
      add(0, 16'h0000, 1, 0, 0, 4'(10 - i), 1, 16'(i), 0, 0);
    add(0, 16'h0000, 1, 0, 0, 1, 1, 16'h000A, 0, 0);
    add(0, 16'h0000, 1, 0, 0, 0, 0, 16'h0000, 0, 0);
    add(1, 16'h1111, 0, 0, 0, 1, 1, 16'h1111, 0, 0);
    add(1, 16'h2222, 0, 0, 0, 2, 1, 16'h1111, 0, 0);
    add(1, 16'h3333, 0, 0, 0, 3, 1, 16'h1111, 0, 0);
    add(1, 16'h9999, 1, 1, 0, 0, 0, 16'h0000, 0, 0);  // flush discards push and pop
    add(1, 16'h4444, 0, 0, 0, 1, 1, 16'h4444, 0, 0);
    add(0, 16'h0000, 1, 0, 0, 0, 0, 16'h0000, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].strobe, vecs[i].din, vecs[i].rdy, vecs[i].fl, vecs[i].clr);
      step();
      check_state($sformatf("vec%0d", i), vecs[i].e_lvl, vecs[i].e_dat, vecs[i].e_ovf);
    end

    // Wrap: 20 push/pop pairs across the pointer wrap.
    for (int i = 0; i < 20; i++) begin
      drive(1, 16'hC000 + 16'(i), 0, 0, 0);
      step();
      check($sformatf("wrap%0d data", i), 32'(out_data), 32'(16'hC000 + 16'(i)));
      check($sformatf("wrap%0d level", i), 32'(level), 32'd1);
      drive(0, 16'h0, 1, 0, 0);
      step();
      check($sformatf("wrap%0d empty", i), 32'(out_valid), 32'd0);
    end

    // Fill, then set-wins on overflow versus clear_flags.
    for (int i = 0; i < 8; i++) begin
      drive(1, 16'h0100 + 16'(i), 0, 0, 0);
      step();
    end
    check_state("fill8", 4'd8, 16'h0100, 1'b0);
    drive(1, 16'hDEAD, 0, 0, 1);
    step();
    check_state("setwins", 4'd8, 16'h0100, 1'b1);
    drive(0, 16'h0, 0, 0, 1);
    step();
    check_state("clr", 4'd8, 16'h0100, 1'b0);
    drive(1, 16'hBEEF, 0, 0, 0);
    step();
    check_state("drop2", 4'd8, 16'h0100, 1'b1);

    // Asynchronous reset mid-cycle, mid-burst.
    drive(1, 16'hF00D, 1, 0, 0);
    #2;
    reset = 1'b0;
    #1;
    check_state("async_rst", 4'd0, 16'h0000, 1'b0);
    step();
    check_state("rst_hold", 4'd0, 16'h0000, 1'b0);
    reset = 1'b1;
    drive(1, 16'h7777, 0, 0, 0);
    step();
    check_state("post_rst", 4'd1, 16'h7777, 1'b0);
    drive(0, 16'h0, 1, 0, 0);
    step();
    check_state("post_rst_pop", 4'd0, 16'h0000, 1'b0);

`ifdef CPU_OUTPUT_FIFO_DROP_COUNT_EN
    check("dc_reset", 32'(drop_count), 32'd0);
    for (int i = 0; i < 8; i++) begin
      drive(1, 16'(i), 0, 0, 0);
      step();
    end
    for (int i = 0; i < 300; i++) begin
      drive(1, 16'hAAAA, 0, 0, 0);
      step();
    end
    check("dc_sat", 32'(drop_count), 32'd255);
    drive(1, 16'hAAAA, 0, 0, 1);
    step();
    check("dc_clr_drop", 32'(drop_count), 32'd1);
    drive(0, 16'h0, 0, 0, 1);
    step();
    check("dc_clr", 32'(drop_count), 32'd0);
`endif

    drive(0, 16'h0, 0, 0, 0);
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
